// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   // Index/counter width that never collapses to zero bits.
   function automatic int clog2w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin picker: first requester at or after rr_ptr, wrapping modulo NUM_REQ.
module rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int IW     = clog2w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      rr_ptr,
   output logic               any_req,
   output logic [IW-1:0]      pick
);

   // Scan from the farthest offset down so the nearest requester wins last.
   always_comb begin
      logic [IW:0] idx;
      idx     = '0;
      pick    = '0;
      any_req = |req;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = {1'b0, rr_ptr} + (IW+1)'(k);
         if (idx >= (IW+1)'(NUM_REQ))
            idx = idx - (IW+1)'(NUM_REQ);
         if (req[idx[IW-1:0]])
            pick = idx[IW-1:0];
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                          clk,
   input  logic                          res,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   input  logic                          full,
   input  logic                          almost_full,
   output logic                          wr_en,
   output logic [DATA_WIDTH-1:0]         wdata,
   output logic                          busy
);

   localparam int IW = clog2w(NUM_REQ);
   localparam int CW = clog2w(MAX_BURST + 1);

   arb_state_t      state, state_nxt;
   logic [IW-1:0]   rr_ptr, rr_nxt;
   logic [IW-1:0]   owner, owner_nxt;
   logic [CW-1:0]   burst_cnt, cnt_nxt;
   logic [CW-1:0]   cnt_inc;
   logic [IW-1:0]   pick, gidx, owner_wrap, pick_wrap;
   logic            any_req, can_write, accept;
   logic [DATA_WIDTH-1:0] sel_data;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
      .req     (req),
      .rr_ptr  (rr_ptr),
      .any_req (any_req),
      .pick    (pick)
   );

   // One free slot left is only safe if nothing is already in flight.
   assign can_write  = !full && !(almost_full && wr_en);
   assign cnt_inc    = burst_cnt + 1'b1;
   assign owner_wrap = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
   assign pick_wrap  = (pick  == IW'(NUM_REQ - 1)) ? '0 : pick  + 1'b1;
   assign busy       = (state == BURST);

   // Next-state, grant and bookkeeping for the IDLE/BURST machine.
   always_comb begin
      state_nxt = state;
      rr_nxt    = rr_ptr;
      owner_nxt = owner;
      cnt_nxt   = burst_cnt;
      gnt       = '0;
      gidx      = owner;
      accept    = 1'b0;
      if (!res) begin
         case (state)
            IDLE: begin
               if (any_req && can_write) begin
                  gidx      = pick;
                  gnt[pick] = 1'b1;
                  accept    = 1'b1;
                  owner_nxt = pick;
                  cnt_nxt   = CW'(1);
                  if (MAX_BURST == 1)
                     rr_nxt = pick_wrap;
                  else
                     state_nxt = BURST;
               end
            end
            BURST: begin
               if (!req[owner]) begin
                  state_nxt = IDLE;
                  rr_nxt    = owner_wrap;
               end else if (can_write) begin
                  gnt[owner] = 1'b1;
                  accept     = 1'b1;
                  cnt_nxt    = cnt_inc;
                  if (cnt_inc == CW'(MAX_BURST)) begin
                     state_nxt = IDLE;
                     rr_nxt    = owner_wrap;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign sel_data = req_data[gidx*DATA_WIDTH +: DATA_WIDTH];

   // State and arbitration registers.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         rr_ptr    <= rr_nxt;
         owner     <= owner_nxt;
         burst_cnt <= cnt_nxt;
      end
   end

   // Registered FIFO write side; wdata holds when nothing is accepted.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         wr_en <= 1'b0;
         wdata <= '0;
      end else begin
         wr_en <= accept;
         if (accept)
            wdata <= sel_data;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with hand-computed expectations.
module tb_fifo_wr_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;

   logic             clk = 1'b0;
   logic             res;
   logic [NR-1:0]    req;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    gnt;
   logic             full, almost_full;
   logic             wr_en;
   logic [DW-1:0]    wdata;
   logic             busy;

   int n_chk  = 0;
   int n_pass = 0;

   fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
      .clk         (clk),
      .res         (res),
      .req         (req),
      .req_data    (req_data),
      .gnt         (gnt),
      .full        (full),
      .almost_full (almost_full),
      .wr_en       (wr_en),
      .wdata       (wdata),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic setd(input int i, input logic [DW-1:0] v);
      req_data[i*DW +: DW] = v;
   endtask

   // Advance to just after the next rising edge; inputs then change for the new cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      res = 1'b1; req = 4'b1111; req_data = '0; full = 1'b0; almost_full = 1'b0;
      for (int i = 0; i < NR; i++) setd(i, 8'(8'h10 + i));
      repeat (3) tick();
      #1;
      chk("rst_gnt",   32'(gnt),   32'h0);
      chk("rst_wr_en", 32'(wr_en), 32'h0);
      chk("rst_wdata", 32'(wdata), 32'h0);
      chk("rst_busy",  32'(busy),  32'h0);

      // Single owner: requester 2 for 6 beats, data 0x20..0x25.
      req = 4'b0000;
      tick();
      res = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) tick();
         req = 4'b0100;
         setd(2, 8'(8'h20 + k));
         #1;
         chk("single_gnt", 32'(gnt), 32'h4);
         if (k == 0) chk("single_wr_en0", 32'(wr_en), 32'h0);
         else begin
            chk("single_wr_en", 32'(wr_en), 32'h1);
            chk("single_wdata", 32'(wdata), 32'(8'h20 + k - 1));
         end
      end
      tick();
      req = 4'b0000;
      #1;
      chk("single_end_gnt",   32'(gnt),   32'h0);
      chk("single_end_wr_en", 32'(wr_en), 32'h1);
      chk("single_end_wdata", 32'(wdata), 32'h25);
      chk("single_end_busy",  32'(busy),  32'h1);
      tick();
      #1;
      chk("single_idle_wr_en", 32'(wr_en), 32'h0);
      chk("single_hold_wdata", 32'(wdata), 32'h25);
      chk("single_idle_busy",  32'(busy),  32'h0);

      // Round-robin fairness after a reset (rr_ptr back to 0).
      res = 1'b1;
      tick();
      res = 1'b0;
      for (int i = 0; i < NR; i++) setd(i, 8'(8'h10 + i));
      for (int k = 0; k < 20; k++) begin
         if (k > 0) tick();
         req = 4'b1111;
         #1;
         chk("rr_gnt", 32'(gnt), 32'(1 << ((k / 4) % 4)));
         if (k > 0) begin
            chk("rr_wr_en", 32'(wr_en), 32'h1);
            chk("rr_wdata", 32'(wdata), 32'(8'h10 + ((k - 1) / 4) % 4));
         end
      end

      // Full stall: owner 1 reaches burst_cnt=2, then full for 3 cycles.
      for (int i = 0; i < NR; i++) setd(i, 8'(8'h30 + i));
      tick(); req = 4'b0111; #1;
      chk("stall_a_gnt", 32'(gnt), 32'h2);
      tick(); #1;
      chk("stall_b_gnt",   32'(gnt),   32'h2);
      chk("stall_b_wr_en", 32'(wr_en), 32'h1);
      chk("stall_b_wdata", 32'(wdata), 32'h31);
      tick(); full = 1'b1; #1;
      chk("stall_c_gnt",   32'(gnt),   32'h0);
      chk("stall_c_wr_en", 32'(wr_en), 32'h1);
      chk("stall_c_busy",  32'(busy),  32'h1);
      tick(); #1;
      chk("stall_d_gnt",   32'(gnt),   32'h0);
      chk("stall_d_wr_en", 32'(wr_en), 32'h0);
      chk("stall_d_busy",  32'(busy),  32'h1);
      tick(); #1;
      chk("stall_e_gnt",   32'(gnt),   32'h0);
      chk("stall_e_wr_en", 32'(wr_en), 32'h0);
      tick(); full = 1'b0; #1;
      chk("stall_f_gnt",   32'(gnt),   32'h2);
      chk("stall_f_wr_en", 32'(wr_en), 32'h0);
      tick(); #1;
      chk("stall_g_gnt",   32'(gnt),   32'h2);
      chk("stall_g_wr_en", 32'(wr_en), 32'h1);
      tick(); #1;
      chk("stall_h_gnt",   32'(gnt),   32'h4);
      chk("stall_h_wdata", 32'(wdata), 32'h31);

      // Drop requests: owner 2 leaves, one bubble, back to IDLE with rr_ptr=3.
      tick(); req = 4'b0000; #1;
      chk("drop_gnt", 32'(gnt), 32'h0);
      tick(); #1;
      chk("drop_busy", 32'(busy), 32'h0);

      // Almost-full: one slot left is granted only when nothing is in flight.
      tick(); req = 4'b1000; setd(3, 8'h55); #1;
      chk("af_a_gnt", 32'(gnt), 32'h8);
      tick(); almost_full = 1'b1; #1;
      chk("af_b_gnt",   32'(gnt),   32'h0);
      chk("af_b_wr_en", 32'(wr_en), 32'h1);
      tick(); #1;
      chk("af_c_gnt",   32'(gnt),   32'h8);
      chk("af_c_wr_en", 32'(wr_en), 32'h0);
      tick(); #1;
      chk("af_d_gnt",   32'(gnt),   32'h0);
      chk("af_d_wr_en", 32'(wr_en), 32'h1);
      chk("af_d_wdata", 32'(wdata), 32'h55);

      // Reset mid-burst (owner 3, burst_cnt=2): async clear, then rr_ptr=0.
      res = 1'b1; #1;
      chk("mid_rst_wr_en", 32'(wr_en), 32'h0);
      chk("mid_rst_gnt",   32'(gnt),   32'h0);
      chk("mid_rst_busy",  32'(busy),  32'h0);
      chk("mid_rst_wdata", 32'(wdata), 32'h0);
      tick(); res = 1'b0; almost_full = 1'b0; req = 4'b1001; #1;
      chk("post_rst_gnt", 32'(gnt), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
